// File: rtl/tnn_seq_pkg.sv
// Shared types and width helpers for the TNN inference sequencer.
// Optional accuracy counting is enabled by defining TNN_SEQ_ACC_EN.
package tnn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD,
    DONE
  } state_e;

  function automatic int pred_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int tmr_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/tnn_seq_timer.sv
// Loadable down-counter with zero flag.
// Used to hold the classifier input for a fixed settle time.
module tnn_seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tnn_infer_sequencer.sv
// Feeds vectors to an external combinational TNN classifier, one at a time.
// Define TNN_SEQ_ACC_EN to latch labels and count correct predictions.
module tnn_infer_sequencer
  import tnn_seq_pkg::*;
#(
  parameter int FEAT_CNT      = 12,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 6,
  parameter int TEST_CNT      = 1000,
  parameter int SETTLE_CYCLES = 2,
  parameter int PRED_W        = pred_w(CLASS_CNT),
  parameter int CNT_W         = cnt_w(TEST_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_CNT*FEAT_BITS-1:0] in_features,
  input  logic [PRED_W-1:0]             in_label,
  output logic [FEAT_CNT*FEAT_BITS-1:0] clf_features,
  input  logic [PRED_W-1:0]             clf_prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PRED_W-1:0]             out_prediction,
  output logic                          out_err,
  output logic [CNT_W-1:0]              sample_cnt,
  output logic [CNT_W-1:0]              correct_cnt,
  output logic                          done
);

  localparam int TMR_W = tmr_w(SETTLE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TCNT = CNT_W'(TEST_CNT);
  localparam logic [PRED_W:0] CLS = (PRED_W + 1)'(CLASS_CNT);

  state_e state_q, state_d;
  logic run_q;
  logic accept, capture, hs;
  logic tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] sample_nxt;
  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
  logic [PRED_W-1:0] pred_q;
  logic err_q;
  logic [CNT_W-1:0] samp_q;

  assign sample_nxt = samp_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    hs       = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && run_q) begin
            accept   = 1'b1;
            tmr_load = 1'b1;
            state_d  = SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_zero) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            hs      = 1'b1;
            state_d = (sample_nxt == TCNT) ? DONE : IDLE;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  tnn_seq_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear),
    .load_i    (tmr_load),
    .load_val_i(TMR_LD),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  // Features only change on accept so the classifier sees a steady input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q <= '0;
      pred_q <= '0;
      err_q  <= 1'b0;
      samp_q <= '0;
    end else if (clear) begin
      pred_q <= '0;
      err_q  <= 1'b0;
      samp_q <= '0;
    end else begin
      if (accept) feat_q <= in_features;
      if (capture) begin
        pred_q <= clf_prediction;
        if ({1'b0, clf_prediction} >= CLS) err_q <= 1'b1;
      end
      if (hs) samp_q <= sample_nxt;
    end
  end

`ifdef TNN_SEQ_ACC_EN
  logic [PRED_W-1:0] label_q;
  logic [CNT_W-1:0] corr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      label_q <= '0;
      corr_q  <= '0;
    end else if (clear) begin
      corr_q <= '0;
    end else begin
      if (accept) label_q <= in_label;
      if (hs && pred_q == label_q) corr_q <= corr_q + 1'b1;
    end
  end

  assign correct_cnt = corr_q;
`else
  logic unused_label;
  assign unused_label = ^in_label;
  assign correct_cnt  = '0;
`endif

  assign in_ready       = (state_q == IDLE) && run_q;
  assign out_valid      = (state_q == HOLD);
  assign done           = (state_q == DONE);
  assign clf_features   = feat_q;
  assign out_prediction = pred_q;
  assign out_err        = err_q;
  assign sample_cnt     = samp_q;

endmodule

// File: tb/tb_tnn_infer_sequencer.sv
// Directed table-driven bench for tnn_infer_sequencer with a stub classifier.
// Stub prediction is the low 3 bits of feature 0.
module tb_tnn_infer_sequencer;

  localparam int FC = 12;
  localparam int FB = 4;
  localparam int FW = FC * FB;

  typedef struct {
    logic [FW-1:0] feat;
    logic [2:0]    label;
    logic [2:0]    pred;
    logic          err;
    int            cnt;
    int            corr;
    int            stall;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_features = '0;
  logic [2:0]    in_label = '0;
  logic [FW-1:0] clf_features;
  logic [2:0]    clf_prediction;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    out_prediction;
  logic          out_err;
  logic [2:0]    sample_cnt;
  logic [2:0]    correct_cnt;
  logic          done;

  int nvec = 0;
  int nerr = 0;
  vec_t tbl[7];

  always #5 clk = ~clk;

  assign clf_prediction = clf_features[2:0];

  tnn_infer_sequencer #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(6),
    .TEST_CNT(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_features(in_features), .in_label(in_label),
    .clf_features(clf_features),
    .clf_prediction(clf_prediction),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prediction(out_prediction), .out_err(out_err),
    .sample_cnt(sample_cnt), .correct_cnt(correct_cnt),
    .done(done)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_corr(input int c);
`ifdef TNN_SEQ_ACC_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic run_vec(input int i);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    in_features = tbl[i].feat;
    in_label    = tbl[i].label;
    @(negedge clk);
    in_valid    = 1'b0;
    in_features = ~tbl[i].feat;
    chk("clf_feat", 64'(clf_features), 64'(tbl[i].feat));
    chk("settle_rdy", 64'(in_ready), 64'd0);
    chk("settle_ov1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("settle_ov2", 64'(out_valid), 64'd0);
    chk("feat_hold", 64'(clf_features), 64'(tbl[i].feat));
    @(negedge clk);
    chk("lat_ov", 64'(out_valid), 64'd1);
    chk("pred", 64'(out_prediction), 64'(tbl[i].pred));
    chk("err", 64'(out_err), 64'(tbl[i].err));
    for (int k = 0; k < tbl[i].stall; k++) begin
      @(negedge clk);
      chk("stall_ov", 64'(out_valid), 64'd1);
      chk("stall_pred", 64'(out_prediction), 64'(tbl[i].pred));
      chk("stall_rdy", 64'(in_ready), 64'd0);
      chk("stall_cnt", 64'(sample_cnt), 64'(tbl[i].cnt - 1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("cnt", 64'(sample_cnt), 64'(tbl[i].cnt));
    chk("corr", 64'(correct_cnt), 64'(exp_corr(tbl[i].corr)));
    chk("hs_ov", 64'(out_valid), 64'd0);
    chk("done", 64'(done), 64'(tbl[i].cnt == 4));
    chk("post_rdy", 64'(in_ready), 64'(tbl[i].cnt != 4));
  endtask

  initial begin
    tbl[0] = '{48'h5A3C_9E71_2B41, 3'd1, 3'd1, 1'b0, 1, 1, 0};
    tbl[1] = '{48'h0123_4567_89A8, 3'd2, 3'd0, 1'b0, 2, 1, 10};
    tbl[2] = '{48'hFFFF_FFFF_FFF3, 3'd3, 3'd3, 1'b0, 3, 2, 0};
    tbl[3] = '{48'h8000_0000_0004, 3'd4, 3'd4, 1'b0, 4, 3, 1};
    tbl[4] = '{48'h1357_9BDF_0247, 3'd0, 3'd7, 1'b1, 1, 0, 0};
    tbl[5] = '{48'hC0DE_CAFE_BEE2, 3'd2, 3'd2, 1'b1, 2, 1, 2};
    tbl[6] = '{48'h0000_0000_0016, 3'd0, 3'd6, 1'b1, 1, 0, 0};

    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_feat", 64'(clf_features), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy0", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rel_rdy1", 64'(in_ready), 64'd1);

    for (int i = 0; i < 4; i++) run_vec(i);

    in_valid    = 1'b1;
    in_features = 48'h0000_0000_0005;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("dn_rdy", 64'(in_ready), 64'd0);
      chk("dn_ov", 64'(out_valid), 64'd0);
      chk("dn_done", 64'(done), 64'd1);
      chk("dn_feat", 64'(clf_features), 64'(tbl[3].feat));
      chk("dn_cnt", 64'(sample_cnt), 64'd4);
    end
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_cnt", 64'(sample_cnt), 64'd0);
    chk("clr_corr", 64'(correct_cnt), 64'd0);
    chk("clr_rdy", 64'(in_ready), 64'd1);

    run_vec(4);
    run_vec(5);

    in_valid    = 1'b1;
    in_features = 48'h0000_0000_0005;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_state", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_ov", 64'(out_valid), 64'd0);
    chk("mr_rdy", 64'(in_ready), 64'd0);
    chk("mr_feat", 64'(clf_features), 64'd0);
    chk("mr_cnt", 64'(sample_cnt), 64'd0);
    chk("mr_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_rel0", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("mr_rel1", 64'(in_ready), 64'd1);

    run_vec(6);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_err", 64'(out_err), 64'd0);
    chk("clr_cnt2", 64'(sample_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
